// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with 2-flop sync, 3-sample majority vote and valid/ready output.
// Define UART_RX_BREAK_EN to add break detection (BREAK state and break_det pulse); otherwise break_det is 0.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick,
    input  logic                 rx,
    input  logic [1:0]           parity_mode,
    input  logic                 rx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun_error,
    output logic                 break_det
);
    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BI_W = $clog2(DATA_BITS);
    localparam int M    = OVERSAMPLE / 2;
    localparam logic [SC_W-1:0] SC_LAST   = SC_W'(OVERSAMPLE - 1);
    localparam logic [SC_W-1:0] SAMP_A    = SC_W'(M - 1);
    localparam logic [SC_W-1:0] SAMP_B    = SC_W'(M);
    localparam logic [SC_W-1:0] SAMP_C    = SC_W'(M + 1);
    localparam logic [BI_W-1:0] BI_LAST   = BI_W'(DATA_BITS - 1);
    localparam logic            STOP_LAST = 1'(STOP_BITS - 1);

`ifdef UART_RX_BREAK_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`endif

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d, sync2_q, sync2_d;
    logic [SC_W-1:0]       sc_q, sc_d;
    logic                  samp_a_q, samp_a_d, samp_b_q, samp_b_d;
    logic [BI_W-1:0]       bit_idx_q, bit_idx_d;
    logic                  stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [1:0]            mode_q, mode_d;
    logic                  perr_acc_q, perr_acc_d, ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, oerr_q, oerr_d;
    logic                  decide, deliver, maj, stop_fe;
`ifdef UART_RX_BREAK_EN
    logic                  zero_q, zero_d, brk_q, brk_d;
`endif

    always_comb begin
        sync1_d    = rx;
        sync2_d    = sync1_q;
        state_d    = state_q;
        sc_d       = sc_q;
        samp_a_d   = samp_a_q;
        samp_b_d   = samp_b_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        mode_d     = mode_q;
        perr_acc_d = perr_acc_q;
        ferr_acc_d = ferr_acc_q;
        data_d     = data_q;
        valid_d    = valid_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        oerr_d     = oerr_q;
        decide     = 1'b0;
        deliver    = 1'b0;
        maj        = (samp_a_q & samp_b_q) | (samp_a_q & sync2_q) | (samp_b_q & sync2_q);
        stop_fe    = ferr_acc_q | ~maj;
`ifdef UART_RX_BREAK_EN
        zero_d     = zero_q;
        brk_d      = 1'b0;
`endif
        // Two samples are stored; the third is the live synchronised input at the decision tick.
        if (tick) begin
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
            if (sc_q == SAMP_A) samp_a_d = sync2_q;
            if (sc_q == SAMP_B) samp_b_d = sync2_q;
            decide = (sc_q == SAMP_C);
        end
        case (state_q)
            IDLE: begin
                if (tick && !sync2_q) begin
                    sc_d    = '0;
                    state_d = START;
                end
            end
            START: begin
                if (decide) begin
                    if (maj) begin
                        state_d = IDLE;
                    end else begin
                        mode_d     = parity_mode;
                        bit_idx_d  = '0;
                        stop_idx_d = 1'b0;
                        perr_acc_d = 1'b0;
                        ferr_acc_d = 1'b0;
`ifdef UART_RX_BREAK_EN
                        zero_d     = 1'b1;
`endif
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shift_d = {maj, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_BREAK_EN
                    zero_d  = zero_q & ~maj;
`endif
                    if (bit_idx_q == BI_LAST) begin
                        state_d = (mode_q == 2'b01 || mode_q == 2'b10) ? PARITY : STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (decide) begin
                    perr_acc_d = ((^shift_q) ^ maj) != (mode_q == 2'b10);
`ifdef UART_RX_BREAK_EN
                    zero_d     = zero_q & ~maj;
`endif
                    state_d    = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    ferr_acc_d = stop_fe;
`ifdef UART_RX_BREAK_EN
                    zero_d     = zero_q & ~maj;
`endif
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = IDLE;
`ifdef UART_RX_BREAK_EN
                        if (zero_q && !maj) begin
                            state_d = BREAK;
                            brk_d   = 1'b1;
                        end else begin
                            deliver = 1'b1;
                        end
`else
                        deliver = 1'b1;
`endif
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_BREAK_EN
            BREAK: begin
                if (tick && sync2_q) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
        // A delivery in the same cycle as an accept replaces the consumed word without flagging overrun.
        if (deliver) begin
            data_d  = shift_q;
            perr_d  = perr_acc_q;
            ferr_d  = stop_fe;
            oerr_d  = valid_q & ~rx_ready;
            valid_d = 1'b1;
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            sc_q       <= '0;
            samp_a_q   <= 1'b1;
            samp_b_q   <= 1'b1;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shift_q    <= '0;
            mode_q     <= 2'b00;
            perr_acc_q <= 1'b0;
            ferr_acc_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            oerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sc_q       <= sc_d;
            samp_a_q   <= samp_a_d;
            samp_b_q   <= samp_b_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            mode_q     <= mode_d;
            perr_acc_q <= perr_acc_d;
            ferr_acc_q <= ferr_acc_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            oerr_q     <= oerr_d;
        end
    end

`ifdef UART_RX_BREAK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b0;
            brk_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            brk_q  <= brk_d;
        end
    end

    assign break_det = brk_q;
`else
    assign break_det = 1'b0;
`endif

    assign rx_data       = data_q;
    assign rx_valid      = valid_q;
    assign parity_error  = perr_q;
    assign frame_error   = ferr_q;
    assign overrun_error = oerr_q;
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, successor to the fixed 8-bit/16x even-parity receiver in the serial datapath. It adds the following over that receiver:
- configurable data width, oversampling ratio and stop-bit count;
- runtime-selectable parity;
- a 2-flop input synchroniser and 3-sample majority voting;
- a valid/ready output handshake with overrun detection;
- optional break detection.

It sits between the shared baud tick generator and the RX byte consumer (FIFO or register file).

## Interface
- DATA_BITS, 8, data bits per frame, legal 5..9
- OVERSAMPLE, 16, ticks per bit, even, legal 8..32
- STOP_BITS, 1, stop bits checked, 1 or 2
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- tick  in  1  oversample enable from baud generator, one clk wide
- rx  in  1  asynchronous serial input, idle high
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready
- rx_data  out  DATA_BITS  received word, LSB first on the line
- rx_valid  out  1  rx_data holds an unconsumed word
- parity_error  out  1  parity mismatch for the word in rx_data
- frame_error  out  1  a stop bit sampled 0 for the word in rx_data
- overrun_error  out  1  the word in rx_data overwrote an unconsumed word
- break_det  out  1  one-clk pulse on a detected break

## Operation
- rx passes through 2 flops into rx_s. All sampling uses rx_s.
- Per-bit sample counter sc runs 0..OVERSAMPLE-1 and advances only on tick.
  - M = OVERSAMPLE/2.
  - The bit value is the majority of rx_s at sc = M-1, M and M+1.
  - The bit is decided on the tick where sc = M+1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK (BREAK only with the macro).
- IDLE: on a tick with rx_s=0, set sc=0 and go to START.
- START: at the decision point:
  - majority 1: false start, go to IDLE;
  - majority 0: latch parity_mode into an internal register, clear the bit index, go to DATA.
- DATA: shift one bit per bit period, LSB first. After DATA_BITS bits, go to PARITY if the latched mode is even or odd, else go to STOP.
- PARITY: even mode expects XOR(data, p) = 0. Odd mode expects XOR(data, p) = 1.
- STOP: decide STOP_BITS bits. frame_error = any stop bit decided 0.
  - Frame completes at the last stop decision.
  - Then go to IDLE, or to BREAK (see Configuration).
- Delivery on frame completion:
  - load rx_data, parity_error and frame_error;
  - set rx_valid = 1;
  - set overrun_error = 1 if rx_valid was 1 and rx_ready was 0 in that cycle, else 0.
- Handshake: rx_valid && rx_ready with no completion in the same cycle clears rx_valid. The error flags hold until the next delivery.
- Simultaneous completion and accept: the old word is consumed and the new word loaded. rx_valid stays 1 and overrun_error = 0.
- parity_mode changes after the start bit is confirmed do not affect the current frame.

## Timing
- Reset values: rx_data = 0, all flags 0, state IDLE, sc = 0, synchroniser flops = 1.
- Reset asserted mid-frame aborts the frame immediately. No partial word is delivered.
- Latency from the rx falling edge to the start detect is 2-3 clk (synchroniser) plus up to 1 tick.
- Delivery occurs in the clk cycle of the tick on which the last stop bit is decided. Nominally this is (1 + DATA_BITS + P + STOP_BITS-1)·OVERSAMPLE + M+1 ticks after start detect, where P = 1 if parity is enabled, else 0.
- rx_valid, rx_data and the error flags change only on a delivery or a handshake clock edge.
- Back-to-back frames: the receiver is back in IDLE with M-2 ticks of the final stop bit remaining, so a next start edge is detected without a lost frame.

## Configuration
- UART_RX_BREAK_EN defined:
  - A break is a frame whose data bits, parity bit (if enabled) and stop bits all decide 0.
  - On a break, break_det pulses for 1 clk. No delivery occurs and rx_valid and the flags are unchanged.
  - The FSM then waits in BREAK until a tick with rx_s=1, then goes to IDLE.
- UART_RX_BREAK_EN undefined:
  - No BREAK state exists and break_det is tied 0.
  - A break frame is delivered as data 0 with frame_error = 1, and the receiver returns to IDLE.
  - A long break therefore produces repeated 0/frame_error words.

## Test plan
Common setup for all scenarios: DATA_BITS=8, OVERSAMPLE=16, STOP_BITS=1, tick every 4 clk.
- Even mode, send 0xA5 with parity bit 0 and stop bit 1 -> rx_data=0xA5, rx_valid=1, parity_error=0, frame_error=0, overrun_error=0. rx_ready pulse -> rx_valid=0.
- Odd mode, same frame as above -> rx_data=0xA5, parity_error=1.
- rx low for 6 ticks then high -> start majority is 1. No delivery, and the FSM is back in IDLE.
- rx_ready=0, send 0x3C then 0xC3 back-to-back in none mode -> after the second frame rx_data=0xC3, overrun_error=1. Then a third frame 0x55, delivered with rx_valid=1 and rx_ready=1 in the delivery cycle -> overrun_error=0.
- Send 0x12 with stop bit 0 -> rx_data=0x12, frame_error=1.
- Macro defined: all-zero even-parity frame, rx held low for 3 more bit times -> a single break_det pulse and no rx_valid. After rx returns high, a 0x81 frame is received normally.
